alu_mem_responder: RTL and testbench

//  Memory-side partner of the processor's memory port: consumes o_memAddr/o_memData/o_memWrEnable

---
 rtl/alu_mem_responder.sv | 146 ++++++++++++++
 tb/tb_alu_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_responder.sv
// Memory-side responder for the processor memory port: word array, fixed-latency read pipeline,
// and a capture FIFO recording every processor write for a downstream monitor.
// Latency: read data RD_LAT cycles after the address; capture entries visible one cycle after the write.
// Backpressure: the capture FIFO drops writes only when full with no pop, counting them in a saturating counter.
module alu_mem_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_AW     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [ADDR_W-1:0]             i_memAddr,
    input  logic [DATA_W-1:0]             i_memWrData,
    input  logic                          i_memWrEnable,
    output logic [DATA_W-1:0]             o_memRdData,
    output logic                          o_addr_err,
    input  logic                          i_ld_en,
    input  logic [MEM_AW-1:0]             i_ld_addr,
    input  logic [DATA_W-1:0]             i_ld_data,
    output logic                          o_ld_drop,
    output logic                          o_wr_valid,
    output logic [ADDR_W-1:0]             o_wr_addr,
    output logic [DATA_W-1:0]             o_wr_data,
    input  logic                          i_wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [7:0]                    o_overflow_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Word array; deliberately has no reset so contents survive a mid-run reset.
    logic [DATA_W-1:0] r_mem [0:(1<<MEM_AW)-1];

    logic [DATA_W-1:0] r_rd_pipe [0:RD_LAT-1];
    logic              r_addr_err;
    logic              r_ld_drop;

    logic [ADDR_W-1:0] r_fifo_addr [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0] r_fifo_data [0:FIFO_DEPTH-1];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [7:0]        r_ovf_cnt;

    logic [MEM_AW-1:0] w_idx;
    logic              w_upper_set;
    logic              w_ld_collide;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;

    // Address decode, preload collision and FIFO handshake qualifiers.
    always_comb begin
        w_idx        = i_memAddr[MEM_AW-1:0];
        w_upper_set  = |i_memAddr[ADDR_W-1:MEM_AW];
        w_ld_collide = i_ld_en && i_memWrEnable && (i_ld_addr == w_idx);
        w_full       = (r_count == CW'(FIFO_DEPTH));
        w_push       = i_memWrEnable;
        w_pop        = (r_count != '0) && i_wr_ready;
        // A push into a full FIFO is only taken when the same edge frees a slot.
        w_accept     = w_push && (!w_full || w_pop);
    end

    // Array writes: preload first so a colliding processor write overrides it.
    always_ff @(posedge i_clk) begin
        if (i_ld_en && !w_ld_collide) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
        if (i_memWrEnable) begin
            r_mem[w_idx] <= i_memWrData;
        end
    end

    // Read pipeline: stage 0 samples the array before this edge's write lands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= r_mem[w_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // One-cycle status pulses for out-of-range access and discarded preload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_err <= 1'b0;
            r_ld_drop  <= 1'b0;
        end else begin
            r_addr_err <= w_upper_set;
            r_ld_drop  <= w_ld_collide;
        end
    end

    // Capture FIFO storage, pointers, occupancy and saturating drop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_fifo_addr[r_wr_ptr] <= i_memAddr;
                r_fifo_data[r_wr_ptr] <= i_memWrData;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && !w_accept && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    // Output mapping; head fields come straight from registered storage.
    always_comb begin
        o_memRdData    = r_rd_pipe[RD_LAT-1];
        o_addr_err     = r_addr_err;
        o_ld_drop      = r_ld_drop;
        o_wr_valid     = (r_count != '0);
        o_wr_addr      = r_fifo_addr[r_rd_ptr];
        o_wr_data      = r_fifo_data[r_rd_ptr];
        o_fifo_count   = r_count;
        o_overflow_cnt = r_ovf_cnt;
    end

endmodule

// File: tb/tb_alu_mem_responder.sv
// Directed bench for alu_mem_responder with default parameters (RD_LAT=1, depth 8).
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_alu_mem_responder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_memAddr;
    logic [15:0] i_memWrData;
    logic        i_memWrEnable;
    logic [15:0] o_memRdData;
    logic        o_addr_err;
    logic        i_ld_en;
    logic [7:0]  i_ld_addr;
    logic [15:0] i_ld_data;
    logic        o_ld_drop;
    logic        o_wr_valid;
    logic [15:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        i_wr_ready;
    logic [3:0]  o_fifo_count;
    logic [7:0]  o_overflow_cnt;

    int checks = 0;
    int errors = 0;

    alu_mem_responder dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_memAddr      (i_memAddr),
        .i_memWrData    (i_memWrData),
        .i_memWrEnable  (i_memWrEnable),
        .o_memRdData    (o_memRdData),
        .o_addr_err     (o_addr_err),
        .i_ld_en        (i_ld_en),
        .i_ld_addr      (i_ld_addr),
        .i_ld_data      (i_ld_data),
        .o_ld_drop      (o_ld_drop),
        .o_wr_valid     (o_wr_valid),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .i_wr_ready     (i_wr_ready),
        .o_fifo_count   (o_fifo_count),
        .o_overflow_cnt (o_overflow_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pop_one();
        i_wr_ready = 1'b1;
        step();
        i_wr_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_memAddr = '0; i_memWrData = '0; i_memWrEnable = 1'b0;
        i_ld_en = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_wr_ready = 1'b0;
        step(); step();
        chk("rst_rd",    32'(o_memRdData), 32'h0);
        chk("rst_cnt",   32'(o_fifo_count), 32'd0);
        chk("rst_vld",   32'(o_wr_valid), 32'd0);
        chk("rst_ovf",   32'(o_overflow_cnt), 32'd0);
        chk("rst_aerr",  32'(o_addr_err), 32'd0);
        chk("rst_ldrop", 32'(o_ld_drop), 32'd0);
        i_rst = 1'b0;
        step();

        // Preload then read back with one-cycle latency; preload is not captured.
        i_ld_en = 1'b1; i_ld_addr = 8'h10; i_ld_data = 16'hBEEF;
        step();
        i_ld_en = 1'b0; i_memAddr = 16'h0010;
        step();
        chk("pre_rd", 32'(o_memRdData), 32'hBEEF);
        chk("pre_nocap", 32'(o_fifo_count), 32'd0);

        // Read-before-write on the same index.
        i_ld_en = 1'b1; i_ld_addr = 8'h20; i_ld_data = 16'hBEEF;
        step();
        i_ld_en = 1'b0;
        i_memAddr = 16'h0020; i_memWrData = 16'h1234; i_memWrEnable = 1'b1;
        step();
        i_memWrEnable = 1'b0;
        chk("rbw_old", 32'(o_memRdData), 32'hBEEF);
        chk("rbw_vld", 32'(o_wr_valid), 32'd1);
        chk("rbw_hadr", 32'(o_wr_addr), 32'h0020);
        chk("rbw_hdat", 32'(o_wr_data), 32'h1234);
        step();
        chk("rbw_new", 32'(o_memRdData), 32'h1234);
        pop_one();
        chk("rbw_popcnt", 32'(o_fifo_count), 32'd0);

        // Out-of-range address: error pulse, index aliasing, full address captured.
        i_memAddr = 16'h0120; i_memWrData = 16'h5A5A; i_memWrEnable = 1'b1;
        step();
        i_memWrEnable = 1'b0; i_memAddr = 16'h0020;
        chk("aerr_on", 32'(o_addr_err), 32'd1);
        chk("aerr_hadr", 32'(o_wr_addr), 32'h0120);
        chk("aerr_hdat", 32'(o_wr_data), 32'h5A5A);
        step();
        chk("aerr_off", 32'(o_addr_err), 32'd0);
        chk("aerr_alias", 32'(o_memRdData), 32'h5A5A);
        pop_one();

        // Ten writes into a depth-8 FIFO with no pops.
        for (int i = 0; i < 10; i++) begin
            i_memAddr = 16'h0040 + 16'(i); i_memWrData = 16'h1000 + 16'(i); i_memWrEnable = 1'b1;
            step();
        end
        i_memWrEnable = 1'b0;
        chk("ovf_cnt", 32'(o_fifo_count), 32'd8);
        chk("ovf_drop", 32'(o_overflow_cnt), 32'd2);
        // Head stays put while not popped.
        step();
        chk("ovf_hold", 32'(o_wr_addr), 32'h0040);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_adr%0d", i), 32'(o_wr_addr), 32'h0040 + i);
            chk($sformatf("drain_dat%0d", i), 32'(o_wr_data), 32'h1000 + i);
            pop_one();
        end
        chk("drain_cnt", 32'(o_fifo_count), 32'd0);
        chk("drain_vld", 32'(o_wr_valid), 32'd0);
        pop_one();
        chk("pop_empty", 32'(o_fifo_count), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            i_memAddr = 16'h0060 + 16'(i); i_memWrData = 16'h2000 + 16'(i); i_memWrEnable = 1'b1;
            step();
        end
        i_memAddr = 16'h0070; i_memWrData = 16'h2FFF; i_wr_ready = 1'b1;
        step();
        i_memWrEnable = 1'b0; i_wr_ready = 1'b0;
        chk("pp_cnt", 32'(o_fifo_count), 32'd8);
        chk("pp_ovf", 32'(o_overflow_cnt), 32'd2);
        chk("pp_head", 32'(o_wr_addr), 32'h0061);

        // Preload collides with processor write (FIFO full, so that write is dropped).
        i_ld_en = 1'b1; i_ld_addr = 8'h05; i_ld_data = 16'hAAAA;
        i_memAddr = 16'h0005; i_memWrData = 16'h5555; i_memWrEnable = 1'b1;
        step();
        i_ld_en = 1'b0; i_memWrEnable = 1'b0;
        chk("col_drop", 32'(o_ld_drop), 32'd1);
        chk("col_ovf", 32'(o_overflow_cnt), 32'd3);
        step();
        chk("col_rd", 32'(o_memRdData), 32'h5555);
        chk("col_dropoff", 32'(o_ld_drop), 32'd0);

        // Preload and processor write to different indices both land.
        i_ld_en = 1'b1; i_ld_addr = 8'h06; i_ld_data = 16'h6666;
        i_memAddr = 16'h0007; i_memWrData = 16'h7777; i_memWrEnable = 1'b1;
        step();
        i_ld_en = 1'b0; i_memWrEnable = 1'b0;
        chk("nc_drop", 32'(o_ld_drop), 32'd0);
        i_memAddr = 16'h0006;
        step();
        chk("nc_ld", 32'(o_memRdData), 32'h6666);
        i_memAddr = 16'h0007;
        step();
        chk("nc_wr", 32'(o_memRdData), 32'h7777);

        // Reset mid-drain: outputs clear asynchronously, array retained.
        i_memAddr = 16'h0005;
        pop_one();
        chk("mid_cnt", 32'(o_fifo_count), 32'd7);
        chk("mid_rd", 32'(o_memRdData), 32'h5555);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(o_fifo_count), 32'd0);
        chk("arst_vld", 32'(o_wr_valid), 32'd0);
        chk("arst_rd", 32'(o_memRdData), 32'h0);
        chk("arst_ovf", 32'(o_overflow_cnt), 32'd0);
        step();
        i_rst = 1'b0;
        step();
        chk("ret_rd", 32'(o_memRdData), 32'h5555);
        chk("ret_cnt", 32'(o_fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
